// File: rtl/user_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_irq_pkg
// Description : Shared constants for the user interrupt router: register
//               word addresses, NMISEL field layout, claim-valid bit, size
//               limits and the fast-line routing mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package user_irq_pkg;

  localparam int c_max_src  = 32;
  localparam int c_max_fast = 15;
  localparam int c_min_src  = 3;

  // Word addresses of the configuration registers
  localparam logic [2:0] c_addr_enable  = 3'd0;
  localparam logic [2:0] c_addr_mode    = 3'd1;
  localparam logic [2:0] c_addr_pending = 3'd2;
  localparam logic [2:0] c_addr_claim   = 3'd3;
  localparam logic [2:0] c_addr_fastmap = 3'd4;
  localparam logic [2:0] c_addr_nmisel  = 3'd5;

  // NMISEL layout: bit 5 valid, bits 4:0 source index
  localparam int c_nmisel_valid_bit = 5;
  localparam int c_nmisel_idx_msb   = 4;
  localparam int c_nmisel_w         = 6;

  // CLAIM read-data valid flag
  localparam int c_claim_valid_bit = 31;

  // Bits of FASTMAP that may be set: source i maps to fast line i-2,
  // so only sources that exist and have a matching fast line qualify.
  function automatic logic [c_max_src-1:0] fast_mask(input int num_src, input int num_fast);
    logic [c_max_src-1:0] m;
    m = '0;
    for (int i = 2; i < c_max_src; i++) begin
      if (i < num_src && (i - 2) < num_fast) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/user_irq_src_cell.sv
`default_nettype none
// ============================================================================
// Module      : user_irq_src_cell
// Description : One interrupt source: optional two-flop synchroniser,
//               previous-sample register and the level/edge pending latch.
//               Optional feature macro: USER_IRQ_SYNC_EN (adds synchroniser).
// Revision    : 1.0 - initial release
// ============================================================================
module user_irq_src_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic edge_mode_i,
  input  logic mode_clr_i,
  input  logic w1c_i,
  input  logic claim_clr_i,
  output logic pending_o
);

  logic w_sample;
  logic r_prev;
  logic r_pending;

`ifdef USER_IRQ_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser for an asynchronous interrupt line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = irq_i;
`endif

  // Pending latch: mode change clears; edge sets beat W1C/claim clears;
  // level sources simply follow the sampled line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_prev <= w_sample;
      if (mode_clr_i) begin
        r_pending <= 1'b0;
      end else if (edge_mode_i) begin
        if (w_sample && !r_prev) begin
          r_pending <= 1'b1;
        end else if (w1c_i || claim_clr_i) begin
          r_pending <= 1'b0;
        end
      end else begin
        r_pending <= w_sample;
      end
    end
  end

  assign pending_o = r_pending;

endmodule
`default_nettype wire

// File: rtl/user_irq_router.sv
`default_nettype none
// ============================================================================
// Module      : user_irq_router
// Description : Routes SoC interrupt sources onto a user core's software,
//               timer, external, fast and NMI pins with per-source enable,
//               level/edge mode, pending, fast mapping, NMI select and claim.
//               Optional feature macro: USER_IRQ_SYNC_EN (input synchroniser).
// Revision    : 1.0 - initial release
// ============================================================================
module user_irq_router
  import user_irq_pkg::*;
#(
  parameter int NUM_SRC  = 32,
  parameter int NUM_FAST = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_SRC-1:0]  irq_i,
  input  logic                reg_req_i,
  input  logic                reg_we_i,
  input  logic [2:0]          reg_addr_i,
  input  logic [31:0]         reg_wdata_i,
  output logic [31:0]         reg_rdata_o,
  output logic                reg_ready_o,
  output logic                irq_software_o,
  output logic                irq_timer_o,
  output logic                irq_external_o,
  output logic [NUM_FAST-1:0] irq_fast_o,
  output logic                irq_nm_o
);

  localparam logic [c_max_src-1:0] c_fast_mask_full  = fast_mask(NUM_SRC, NUM_FAST);
  localparam logic [NUM_SRC-1:0]   c_fast_mask       = c_fast_mask_full[NUM_SRC-1:0];
  localparam logic [c_max_src-1:0] c_route_mask_full = 32'hFFFF_FFFC;
  localparam logic [NUM_SRC-1:0]   c_route_mask      = c_route_mask_full[NUM_SRC-1:0];

  logic [NUM_SRC-1:0]    r_en;
  logic [NUM_SRC-1:0]    r_mode;
  logic [NUM_SRC-1:0]    r_fastmap;
  logic [c_nmisel_w-1:0] r_nmisel;
  logic                  r_ready;
  logic [31:0]           r_rdata;

  logic                  w_wr;
  logic                  w_rd;
  logic [NUM_SRC-1:0]    w_wdata_src;
  logic [NUM_SRC-1:0]    w_pending;
  logic [NUM_SRC-1:0]    w_ext_set;
  logic [NUM_SRC-1:0]    w_mode_clr;
  logic [NUM_SRC-1:0]    w_w1c;
  logic [NUM_SRC-1:0]    w_claim_clr;
  logic [31:0]           w_en32;
  logic [31:0]           w_mode32;
  logic [31:0]           w_pend32;
  logic [31:0]           w_fast32;
  logic [31:0]           w_ext32;
  logic [31:0]           w_claim_hot32;
  logic                  w_claim_found;
  logic [4:0]            w_claim_idx;
  logic [31:0]           w_rdata_next;

  assign w_wr        = reg_req_i & reg_we_i;
  assign w_rd        = reg_req_i & ~reg_we_i;
  assign w_wdata_src = reg_wdata_i[NUM_SRC-1:0];

  // Sources eligible for the external pin (and therefore for claim)
  assign w_ext_set = w_pending & r_en & ~r_fastmap & c_route_mask;

  // Zero-extend per-source vectors to the 32-bit register width
  always_comb begin
    w_en32   = '0;
    w_mode32 = '0;
    w_pend32 = '0;
    w_fast32 = '0;
    w_ext32  = '0;
    w_en32[NUM_SRC-1:0]   = r_en;
    w_mode32[NUM_SRC-1:0] = r_mode;
    w_pend32[NUM_SRC-1:0] = w_pending;
    w_fast32[NUM_SRC-1:0] = r_fastmap;
    w_ext32[NUM_SRC-1:0]  = w_ext_set;
  end

  // Claim picks the lowest-numbered external source (descending scan, last hit wins)
  always_comb begin
    w_claim_found = 1'b0;
    w_claim_idx   = '0;
    for (int i = c_max_src - 1; i >= 2; i--) begin
      if (w_ext32[i]) begin
        w_claim_found = 1'b1;
        w_claim_idx   = 5'(i);
      end
    end
  end

  assign w_claim_hot32 = 32'd1 << w_claim_idx;

  // Per-source clear strobes derived from the current register access
  always_comb begin
    w_mode_clr  = '0;
    w_w1c       = '0;
    w_claim_clr = '0;
    if (w_wr && reg_addr_i == c_addr_mode)    w_mode_clr = w_wdata_src ^ r_mode;
    if (w_wr && reg_addr_i == c_addr_pending) w_w1c      = w_wdata_src & r_mode;
    if (w_rd && reg_addr_i == c_addr_claim && w_claim_found) begin
      w_claim_clr = w_claim_hot32[NUM_SRC-1:0] & r_mode;
    end
  end

  // Read data multiplexer
  always_comb begin
    w_rdata_next = '0;
    case (reg_addr_i)
      c_addr_enable:  w_rdata_next = w_en32;
      c_addr_mode:    w_rdata_next = w_mode32;
      c_addr_pending: w_rdata_next = w_pend32;
      c_addr_claim: begin
        if (w_claim_found) begin
          w_rdata_next[c_claim_valid_bit] = 1'b1;
          w_rdata_next[4:0]               = w_claim_idx;
        end
      end
      c_addr_fastmap: w_rdata_next = w_fast32;
      c_addr_nmisel:  w_rdata_next[c_nmisel_w-1:0] = r_nmisel;
      default:        w_rdata_next = '0;
    endcase
  end

  // Configuration registers and one-cycle access handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en      <= '0;
      r_mode    <= '0;
      r_fastmap <= '0;
      r_nmisel  <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_ready <= reg_req_i;
      r_rdata <= w_rd ? w_rdata_next : 32'd0;
      if (w_wr) begin
        case (reg_addr_i)
          c_addr_enable:  r_en      <= w_wdata_src;
          c_addr_mode:    r_mode    <= w_wdata_src;
          c_addr_fastmap: r_fastmap <= w_wdata_src & c_fast_mask;
          c_addr_nmisel:  r_nmisel  <= reg_wdata_i[c_nmisel_w-1:0];
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    user_irq_src_cell u_cell (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .irq_i       (irq_i[i]),
      .edge_mode_i (r_mode[i]),
      .mode_clr_i  (w_mode_clr[i]),
      .w1c_i       (w_w1c[i]),
      .claim_clr_i (w_claim_clr[i]),
      .pending_o   (w_pending[i])
    );
  end

  for (genvar k = 0; k < NUM_FAST; k++) begin : g_fast
    if (k + 2 < NUM_SRC) begin : g_map
      assign irq_fast_o[k] = w_pending[k+2] & r_en[k+2] & r_fastmap[k+2];
    end else begin : g_none
      assign irq_fast_o[k] = 1'b0;
    end
  end

  assign irq_software_o = w_pending[0] & r_en[0];
  assign irq_timer_o    = w_pending[1] & r_en[1];
  assign irq_external_o = |w_ext_set;
  // NMI ignores enable; indices beyond NUM_SRC hit zero-extended bits
  assign irq_nm_o       = r_nmisel[c_nmisel_valid_bit] & w_pend32[r_nmisel[c_nmisel_idx_msb:0]];

  assign reg_ready_o = r_ready;
  assign reg_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_user_irq_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_irq_router
// Description : Self-checking bench for user_irq_router; register reads are
//               scored against a queue of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_irq_router;
  import user_irq_pkg::*;

  localparam int NUM_SRC  = 32;
  localparam int NUM_FAST = 15;
`ifdef USER_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_SRC-1:0]  irq;
  logic                req;
  logic                we;
  logic [2:0]          addr;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  logic                ready;
  logic                sw;
  logic                tm;
  logic                ext;
  logic [NUM_FAST-1:0] fast;
  logic                nm;

  typedef struct packed {
    logic        is_read;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  sb_t sb_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_resp   = 0;

  always #5 clk = ~clk;

  user_irq_router #(.NUM_SRC(NUM_SRC), .NUM_FAST(NUM_FAST)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .irq_i          (irq),
    .reg_req_i      (req),
    .reg_we_i       (we),
    .reg_addr_i     (addr),
    .reg_wdata_i    (wdata),
    .reg_rdata_o    (rdata),
    .reg_ready_o    (ready),
    .irq_software_o (sw),
    .irq_timer_o    (tm),
    .irq_external_o (ext),
    .irq_fast_o     (fast),
    .irq_nm_o       (nm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Packed view of all irq outputs: {fast, sw, tm, ext, nm}
  function automatic logic [31:0] outs();
    return {13'd0, fast, sw, tm, ext, nm};
  endfunction

  // Present one access at the current negedge and queue its expectation
  task automatic issue(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sb_q.push_back('{is_read: !w, exp: exp});
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    issue(1'b1, a, d, 32'd0);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    issue(1'b0, a, 32'd0, exp);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Response monitor: every ready pulse pops one expectation
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        n_resp++;
        if (sb_e.is_read) check($sformatf("rdata#%0d", n_resp), rdata, sb_e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1; irq = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    reg_rd(c_addr_enable, 32'd0);
    reg_rd(c_addr_mode, 32'd0);
    reg_rd(c_addr_fastmap, 32'd0);
    reg_rd(c_addr_nmisel, 32'd0);
    reg_rd(c_addr_claim, 32'd0);

    // Level source 2 on the external pin
    reg_wr(c_addr_enable, 32'h4);
    reg_wr(c_addr_mode, 32'h0);
    reg_rd(c_addr_enable, 32'h4);
    @(negedge clk); irq[2] = 1'b1;
    #1 check("ext_too_early", {31'd0, ext}, 32'd0);
    repeat (LAT) @(negedge clk);
    check("ext_level_rise", outs(), 32'h2);
    reg_rd(c_addr_claim, 32'h8000_0002);
    check("ext_level_after_claim", {31'd0, ext}, 32'd1);
    @(negedge clk); irq[2] = 1'b0;
    repeat (LAT) @(negedge clk);
    check("ext_level_fall", {31'd0, ext}, 32'd0);

    // Edge source 3: pulse latches, claim clears
    reg_wr(c_addr_mode, 32'h8);
    reg_wr(c_addr_enable, 32'h8);
    @(negedge clk); irq[3] = 1'b1;
    @(negedge clk); irq[3] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("edge_pend_held", {31'd0, ext}, 32'd1);
    reg_rd(c_addr_pending, 32'h8);
    reg_rd(c_addr_claim, 32'h8000_0003);
    check("ext_after_claim", {31'd0, ext}, 32'd0);
    reg_rd(c_addr_claim, 32'd0);
    reg_rd(c_addr_pending, 32'd0);

    // Level->edge mode change clears pending; no new edge while held
    @(negedge clk); irq[2] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    reg_rd(c_addr_pending, 32'h4);
    reg_wr(c_addr_mode, 32'hC);
    reg_rd(c_addr_pending, 32'h0);
    reg_wr(c_addr_mode, 32'h8);
    repeat (LAT + 1) @(negedge clk);

    // W1C: clears edge source 3, ignored by level source 2
    @(negedge clk); irq[3] = 1'b1;
    @(negedge clk); irq[3] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    reg_rd(c_addr_pending, 32'hC);
    reg_wr(c_addr_pending, 32'hC);
    reg_rd(c_addr_pending, 32'h4);

    // New edge on src3 lands on the same edge as its W1C: set wins
    @(negedge clk); irq[3] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    issue(1'b1, c_addr_pending, 32'h8, 32'd0);
    @(negedge clk); req = 1'b0;
    reg_rd(c_addr_pending, 32'hC);
    @(negedge clk); irq[3] = 1'b0; irq[2] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    reg_wr(c_addr_pending, 32'h8);
    reg_rd(c_addr_pending, 32'h0);

    // Fast mapping of source 4 onto fast line 2
    reg_wr(c_addr_fastmap, 32'h10);
    reg_wr(c_addr_enable, 32'h10);
    @(negedge clk); irq[4] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("fast_line2", outs(), 32'h40);
    reg_wr(c_addr_fastmap, 32'hFFFF_FFFF);
    reg_rd(c_addr_fastmap, 32'h0001_FFFC);
    reg_wr(c_addr_fastmap, 32'h0);
    check("fast_unmapped_ext", outs(), 32'h2);
    @(negedge clk); irq[4] = 1'b0;
    repeat (LAT) @(negedge clk);

    // NMI from source 5, independent of enable
    reg_wr(c_addr_enable, 32'h0);
    reg_wr(c_addr_nmisel, 32'h25);
    @(negedge clk); irq[5] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("nmi_only", outs(), 32'h1);
    reg_rd(c_addr_nmisel, 32'h25);
    reg_wr(c_addr_nmisel, 32'h05);
    check("nmi_invalid", {31'd0, nm}, 32'd0);
    @(negedge clk); irq[5] = 1'b0;
    reg_rd(3'd6, 32'd0);

    // Back-to-back reads with req held high
    reg_wr(c_addr_enable, 32'h3);
    @(negedge clk); issue(1'b0, c_addr_enable, 32'd0, 32'h3);
    @(negedge clk); issue(1'b0, c_addr_mode, 32'd0, 32'h8);
    @(negedge clk); req = 1'b0;

    // Software irq latency, then reset in the middle of the pulse
    @(negedge clk); irq[0] = 1'b1;
    #1 check("sw_too_early", {31'd0, sw}, 32'd0);
    repeat (LAT) @(negedge clk);
    check("sw_rise", outs(), 32'h8);
    rst = 1'b1;
    @(negedge clk);
    check("outs_after_rst", outs(), 32'd0);
    check("ready_after_rst", {31'd0, ready}, 32'd0);
    rst = 1'b0; irq = '0;
    reg_rd(c_addr_enable, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
